// File: rtl/vx_tcu_drl_pkg.sv
// vx_tcu_drl_pkg: shared exception codes, fp32 field widths and output sizing for the DRL align/accumulate stage
package vx_tcu_drl_pkg;
   localparam logic [1:0] EXC_NONE = 2'b00;
   localparam logic [1:0] EXC_INF  = 2'b01;
   localparam logic [1:0] EXC_NAN  = 2'b10;
   localparam int FP32_EXP_W  = 8;
   localparam int FP32_FRAC_W = 23;
   localparam int FP32_SIG_W  = FP32_FRAC_W + 1;
   localparam int INT_LANE_W  = 25;
   function automatic int ACC_OUT_W(input int n, input int w);
      return w + $clog2(n) + 1;
   endfunction
endpackage

// File: rtl/vx_tcu_drl_align_shift.sv
// vx_tcu_drl_align_shift: aligns one operand to the common exponent, keeps a sticky bit when VX_TCU_DRL_STICKY_EN is defined, then applies its sign
module vx_tcu_drl_align_shift #(
   parameter int W  = 53,
   parameter int AW = 57
) (
   input  logic [W-1:0]  sig,
   input  logic [7:0]    diff,
   input  logic          neg,
   output logic [AW-1:0] val
);
   localparam logic [7:0] W8 = 8'(W);
   logic          big;
   logic [W-1:0]  sh;
   logic [AW-1:0] mag;
   // right shift by the exponent gap; a gap of W or more leaves nothing
   always_comb begin
      big = diff >= W8;
      sh  = big ? '0 : sig >> diff;
`ifdef VX_TCU_DRL_STICKY_EN
      sh[0] = sh[0] | (big ? (|sig) : (|(sig & ~({W{1'b1}} << diff))));
`endif
      mag = {{(AW-W){1'b0}}, sh};
      val = neg ? -mag : mag;
   end
endmodule

// File: rtl/vx_tcu_drl_align_acc.sv
// vx_tcu_drl_align_acc: 3-stage elastic align-and-accumulate of N-1 products plus C; VX_TCU_DRL_STICKY_EN keeps shifted-out bits as sticky
module vx_tcu_drl_align_acc
   import vx_tcu_drl_pkg::*;
#(
   parameter int N  = 5,
   parameter int W  = 53,
   parameter int PW = 22
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid_in,
   output logic                       ready_in,
   input  logic                       fmt_sel_in,
   input  logic [N-2:0]               prod_sign,
   input  logic [(N-1)*8-1:0]         prod_exp,
   input  logic [(N-1)*PW-1:0]        prod_sig,
   input  logic [N-2:0]               prod_inf,
   input  logic [N-2:0]               prod_nan,
   input  logic [31:0]                c_val,
   output logic                       valid_out,
   input  logic                       ready_out,
   output logic [7:0]                 max_exp,
   output logic [ACC_OUT_W(N,W)-1:0]  acc_sig,
   output logic [6:0]                 hi_c,
   output logic [N-2:0]               sig_signs,
   output logic                       fmt_sel,
   output logic [2:0]                 exceptions
);
   localparam int M  = N - 1;
   localparam int AW = ACC_OUT_W(N, W);
   localparam int LO = W - INT_LANE_W;

   logic v1, v2, v3, en1, en2, en3;
   assign en3       = ~v3 | ready_out;
   assign en2       = ~v2 | en3;
   assign en1       = ~v1 | en2;
   assign ready_in  = en1;
   assign valid_out = v3;

   logic                  c_inf, c_nan, pos_inf, neg_inf, any_nan;
   logic [2:0]            exc_d;
   logic [FP32_EXP_W-1:0] c_exp;
   // classify C and the products into the fp exception code; int mode never raises one
   always_comb begin
      c_exp   = c_val[FP32_FRAC_W +: FP32_EXP_W];
      c_inf   = (&c_exp) & ~(|c_val[FP32_FRAC_W-1:0]);
      c_nan   = (&c_exp) & (|c_val[FP32_FRAC_W-1:0]);
      any_nan = (|prod_nan) | c_nan;
      pos_inf = (|(prod_inf & ~prod_sign)) | (c_inf & ~c_val[31]);
      neg_inf = (|(prod_inf & prod_sign)) | (c_inf & c_val[31]);
      exc_d   = fmt_sel_in ? {1'b0, EXC_NONE} : (any_nan | (pos_inf & neg_inf)) ? {1'b0, EXC_NAN} : (pos_inf | neg_inf) ? {neg_inf, EXC_INF} : {1'b0, EXC_NONE};
   end

   logic                  f1;
   logic [M-1:0]          sn1;
   logic [M*8-1:0]        pe1;
   logic [M*PW-1:0]       pg1;
   logic [31:0]           c1;
   logic [FP32_SIG_W-1:0] cs1;
   logic [2:0]            x1;
   // stage 1: capture operands, C significand flushed to zero when its exponent is zero
   always_ff @(posedge clk) begin
      if (reset) begin
         v1 <= 1'b0; f1 <= 1'b0; sn1 <= '0; pe1 <= '0; pg1 <= '0; c1 <= '0; cs1 <= '0; x1 <= '0;
      end else begin
         if (en1) v1 <= valid_in;
         if (en1 & valid_in) begin
            f1  <= fmt_sel_in;
            sn1 <= prod_sign;
            pe1 <= prod_exp;
            pg1 <= prod_sig;
            c1  <= c_val;
            cs1 <= (c_exp == '0) ? '0 : {1'b1, c_val[FP32_FRAC_W-1:0]};
            x1  <= exc_d;
         end
      end
   end

   logic [7:0]   e  [N];
   logic [W-1:0] pl [N];
   logic [7:0]   mx;
   // common exponent and each operand placed at its pre-shift position (int lanes sit at the top fraction bits)
   always_comb begin
      for (int i = 0; i < M; i++) begin
         e[i]  = pe1[i*8 +: 8];
         pl[i] = f1 ? {INT_LANE_W'(pg1[i*PW +: PW]), {LO{1'b0}}} : (e[i] == '0) ? '0 : {pg1[i*PW +: PW], {(W-PW){1'b0}}};
      end
      e[M]  = c1[FP32_FRAC_W +: FP32_EXP_W];
      pl[M] = f1 ? {c1[INT_LANE_W-1:0], {LO{1'b0}}} : {1'b0, cs1, {LO{1'b0}}};
      mx = '0;
      for (int i = 0; i < N; i++) mx = (e[i] > mx) ? e[i] : mx;
      mx = f1 ? '0 : mx;
   end

   logic           f2;
   logic [M-1:0]   sn2;
   logic [6:0]     hc2;
   logic [2:0]     x2;
   logic [7:0]     mx2;
   logic [W-1:0]   pl2 [N];
   logic [7:0]     d2  [N];
   logic [N-1:0]   n2;
   // stage 2: register the alignment distance and sign of every operand
   always_ff @(posedge clk) begin
      if (reset) begin
         v2 <= 1'b0; f2 <= 1'b0; sn2 <= '0; hc2 <= '0; x2 <= '0; mx2 <= '0; n2 <= '0;
         for (int i = 0; i < N; i++) begin
            pl2[i] <= '0;
            d2[i]  <= '0;
         end
      end else begin
         if (en2) v2 <= v1;
         if (en2 & v1) begin
            f2  <= f1;
            sn2 <= sn1;
            hc2 <= c1[31:25];
            x2  <= x1;
            mx2 <= mx;
            n2  <= f1 ? '0 : {c1[31], sn1};
            for (int i = 0; i < N; i++) begin
               pl2[i] <= pl[i];
               d2[i]  <= f1 ? '0 : mx - e[i];
            end
         end
      end
   end

   logic [AW-1:0] a [N];
   logic [AW-1:0] sum;
   for (genvar i = 0; i < N; i++) begin : g_shift
      vx_tcu_drl_align_shift #(.W(W), .AW(AW)) u_shift (.sig(pl2[i]), .diff(d2[i]), .neg(n2[i]), .val(a[i]));
   end
   // two's-complement reduction of the aligned operands
   always_comb begin
      sum = '0;
      for (int i = 0; i < N; i++) sum = sum + a[i];
   end

   // stage 3: output register, held while the downstream stalls
   always_ff @(posedge clk) begin
      if (reset) begin
         v3 <= 1'b0; max_exp <= '0; acc_sig <= '0; hi_c <= '0; sig_signs <= '0; fmt_sel <= 1'b0; exceptions <= '0;
      end else begin
         if (en3) v3 <= v2;
         if (en3 & v2) begin
            max_exp    <= mx2;
            acc_sig    <= sum;
            hi_c       <= hc2;
            sig_signs  <= sn2;
            fmt_sel    <= f2;
            exceptions <= x2;
         end
      end
   end
endmodule

// File: tb/tb_vx_tcu_drl_align_acc.sv
// tb_vx_tcu_drl_align_acc: directed and random checks of the align/accumulate stage against a value-level model
module tb_vx_tcu_drl_align_acc;
   localparam int N  = 5;
   localparam int W  = 53;
   localparam int PW = 22;
   localparam int M  = N - 1;
   localparam int AW = W + $clog2(N) + 1;
   localparam logic [PW-1:0] ONE = PW'(1 << (PW - 2));

   typedef struct {
      logic            fmt;
      logic [M-1:0]    sgn;
      logic [M-1:0]    inf;
      logic [M-1:0]    nan;
      logic [M*8-1:0]  pe;
      logic [M*PW-1:0] ps;
      logic [31:0]     c;
   } txn_t;

   typedef struct {
      logic [7:0]    mx;
      logic [AW-1:0] acc;
      logic [2:0]    exc;
      logic [6:0]    hic;
      logic [M-1:0]  sgn;
      logic          fmt;
   } res_t;

   logic clk = 1'b0;
   logic reset, valid_in, ready_in, fmt_sel_in, valid_out, ready_out, fmt_sel;
   logic [M-1:0]    prod_sign, prod_inf, prod_nan, sig_signs;
   logic [M*8-1:0]  prod_exp;
   logic [M*PW-1:0] prod_sig;
   logic [31:0]     c_val;
   logic [7:0]      max_exp;
   logic [AW-1:0]   acc_sig;
   logic [6:0]      hi_c;
   logic [2:0]      exceptions;

   int n_pass = 0, n_total = 0, n_fail = 0;
   int sent, got, lat;
   logic held;
   logic [AW-1:0] last_acc;
   txn_t bt [5];
   res_t q [$];

   always #5 clk = ~clk;

   vx_tcu_drl_align_acc #(.N(N), .W(W), .PW(PW)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
      .fmt_sel_in(fmt_sel_in), .prod_sign(prod_sign), .prod_exp(prod_exp), .prod_sig(prod_sig),
      .prod_inf(prod_inf), .prod_nan(prod_nan), .c_val(c_val),
      .valid_out(valid_out), .ready_out(ready_out), .max_exp(max_exp), .acc_sig(acc_sig),
      .hi_c(hi_c), .sig_signs(sig_signs), .fmt_sel(fmt_sel), .exceptions(exceptions)
   );

   function automatic txn_t mk(input logic fmt, input logic [M*8-1:0] pe, input logic [M*PW-1:0] ps,
                               input logic [M-1:0] sg, input logic [M-1:0] inf, input logic [M-1:0] nan, input logic [31:0] c);
      txn_t t;
      t.fmt = fmt; t.pe = pe; t.ps = ps; t.sgn = sg; t.inf = inf; t.nan = nan; t.c = c;
      return t;
   endfunction

   function automatic txn_t rand_txn(input logic fmt);
      txn_t t;
      t.fmt = fmt;
      t.sgn = M'($urandom);
      t.inf = ($urandom_range(0, 5) == 0) ? M'($urandom) : '0;
      t.nan = ($urandom_range(0, 7) == 0) ? M'($urandom) : '0;
      for (int i = 0; i < M; i++) begin
         t.pe[i*8 +: 8]  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(90, 160));
         t.ps[i*PW +: PW] = PW'($urandom) | PW'(1 << (PW - 3));
      end
      t.c = {1'($urandom), (($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(40, 170))), 23'($urandom)};
      return t;
   endfunction

   // value-level reference: each operand is sign * significand * 2^(exp - max_exp), scaled so 1.0 sits at bit W-2
   function automatic res_t model(input txn_t t);
      res_t r;
      logic [63:0] m [N];
      int e [N];
      logic [N-1:0] s;
      logic [63:0] a, v;
      int mx, d;
      bit pi, ni, nn, cinf;
      r.hic = t.c[31:25]; r.sgn = t.sgn; r.fmt = t.fmt;
      v = 64'd0;
      if (t.fmt) begin
         v = 64'(t.c[24:0]);
         for (int i = 0; i < M; i++) v = v + 64'(t.ps[i*PW +: PW]);
         r.mx = 8'd0; r.exc = 3'b000; r.acc = AW'(v << (W - 25));
         return r;
      end
      s = {t.c[31], t.sgn};
      for (int i = 0; i < M; i++) begin
         e[i] = int'(t.pe[i*8 +: 8]);
         m[i] = (e[i] == 0) ? 64'd0 : (64'(t.ps[i*PW +: PW]) << (W - PW));
      end
      e[M] = int'(t.c[30:23]);
      m[M] = (e[M] == 0) ? 64'd0 : (64'({1'b1, t.c[22:0]}) << (W - 25));
      mx = 0;
      for (int i = 0; i < N; i++) if (e[i] > mx) mx = e[i];
      for (int i = 0; i < N; i++) begin
         d = mx - e[i];
         a = (d >= 64) ? 64'd0 : (m[i] >> d);
`ifdef VX_TCU_DRL_STICKY_EN
         if ((d >= 64) ? (m[i] != 0) : ((m[i] & ((64'd1 << d) - 64'd1)) != 0)) a[0] = 1'b1;
`endif
         v = s[i] ? v - a : v + a;
      end
      nn   = (|t.nan) || (t.c[30:23] == 8'hFF && t.c[22:0] != 0);
      cinf = (t.c[30:23] == 8'hFF && t.c[22:0] == 0);
      pi   = (|(t.inf & ~t.sgn)) || (cinf && !t.c[31]);
      ni   = (|(t.inf & t.sgn)) || (cinf && t.c[31]);
      r.exc = (nn || (pi && ni)) ? 3'b010 : (pi || ni) ? {ni, 2'b01} : 3'b000;
      r.mx  = 8'(mx);
      r.acc = AW'(v);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_total++;
      assert (obs === want) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic drive(input txn_t t);
      fmt_sel_in = t.fmt; prod_sign = t.sgn; prod_exp = t.pe; prod_sig = t.ps;
      prod_inf = t.inf; prod_nan = t.nan; c_val = t.c;
   endtask

   task automatic check_out(input string tag, input res_t r);
      chk({tag, "_max_exp"}, 64'(max_exp), 64'(r.mx));
      chk({tag, "_exc"}, 64'(exceptions), 64'(r.exc));
      if (r.exc == 3'b000) chk({tag, "_acc"}, 64'(acc_sig), 64'(r.acc));
      chk({tag, "_hi_c"}, 64'(hi_c), 64'(r.hic));
      chk({tag, "_signs"}, 64'(sig_signs), 64'(r.sgn));
      chk({tag, "_fmt"}, 64'(fmt_sel), 64'(r.fmt));
   endtask

   // one isolated transaction: entered at posedge+1 with the pipeline empty, leaves after the output is taken
   task automatic run_one(input string tag, input txn_t t);
      drive(t); valid_in = 1'b1; ready_out = 1'b1;
      #1;
      chk({tag, "_ready_in"}, 64'(ready_in), 64'd1);
      @(posedge clk); #1;
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd3);
      check_out(tag, model(t));
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
      drive(mk(1'b0, '0, '0, '0, '0, '0, 32'd0));
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_valid_out", 64'(valid_out), 64'd0);
      chk("rst_ready_in", 64'(ready_in), 64'd1);
      chk("rst_acc", 64'(acc_sig), 64'd0);
      chk("rst_max_exp", 64'(max_exp), 64'd0);
      chk("rst_exc", 64'(exceptions), 64'd0);

      run_one("ones", mk(1'b0, {M{8'd127}}, {M{ONE}}, '0, '0, '0, 32'h3F80_0000));
      chk("ones_acc_const", 64'(acc_sig), 64'd5 << 51);
      chk("ones_exp_const", 64'(max_exp), 64'd127);

      run_one("cancel", mk(1'b0, {8'd0, 8'd0, 8'd127, 8'd127}, {M{ONE}}, 4'b0010, '0, '0, 32'd0));
      chk("cancel_acc_const", 64'(acc_sig), 64'd0);

      run_one("gap27", mk(1'b0, {8'd0, 8'd0, 8'd0, 8'd127}, {{(3*PW){1'b0}}, ONE}, '0, '0, '0, 32'(100) << 23));
      chk("gap27_acc_const", 64'(acc_sig), (64'd1 << 51) + (64'd1 << 24));

      run_one("gap126", mk(1'b0, {8'd0, 8'd0, 8'd0, 8'd127}, {{(3*PW){1'b0}}, ONE}, '0, '0, '0, 32'd1 << 23));
`ifdef VX_TCU_DRL_STICKY_EN
      chk("gap126_acc_const", 64'(acc_sig), (64'd1 << 51) | 64'd1);
`else
      chk("gap126_acc_const", 64'(acc_sig), 64'd1 << 51);
`endif

      run_one("inf_both", mk(1'b0, {8'd127, 8'd255, 8'd127, 8'd255}, {M{ONE}}, 4'b0100, 4'b0101, '0, 32'd0));
      chk("inf_both_const", 64'(exceptions), 64'b010);
      run_one("inf_neg", mk(1'b0, {8'd127, 8'd127, 8'd255, 8'd127}, {M{ONE}}, 4'b0010, 4'b0010, '0, 32'd0));
      chk("inf_neg_const", 64'(exceptions), 64'b101);
      run_one("nan_p3", mk(1'b0, {M{8'd127}}, {M{ONE}}, '0, '0, 4'b1000, 32'h3F80_0000));
      run_one("c_neg_inf", mk(1'b0, {M{8'd127}}, {M{ONE}}, '0, '0, '0, 32'hFF80_0000));
      run_one("c_nan", mk(1'b0, {M{8'd127}}, {M{ONE}}, '0, 4'b0001, '0, 32'h7FC0_0001));

      run_one("int_max", mk(1'b1, {M{8'd200}}, {(M*PW){1'b1}}, 4'hF, 4'b0011, 4'b0100, 32'h0200_0001));
      chk("int_hi_c_const", 64'(hi_c), 64'd1);
      chk("int_signs_const", 64'(sig_signs), 64'hF);

      for (int k = 0; k < 30; k++) run_one("rand_fp", rand_txn(1'b0));
      for (int k = 0; k < 10; k++) run_one("rand_int", rand_txn(1'b1));

      // backpressure: stalled downstream for six cycles while five transactions are offered
      for (int i = 0; i < 5; i++) bt[i] = rand_txn(1'b0);
      sent = 0; got = 0; held = 1'b0; last_acc = '0;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         ready_out = (cyc >= 6);
         valid_in  = (sent < 5);
         if (sent < 5) drive(bt[sent]);
         @(negedge clk);
         if (cyc == 3) begin
            chk("bp_ready_low", 64'(ready_in), 64'd0);
            chk("bp_accepted", 64'(sent), 64'd3);
         end
         if (held) chk("bp_stable_acc", 64'(acc_sig), 64'(last_acc));
         if (valid_out) begin
            chk("bp_out_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               check_out("bp_out", q[0]);
               if (ready_out) begin
                  void'(q.pop_front());
                  got++;
               end
            end
         end
         held     = valid_out & ~ready_out;
         last_acc = acc_sig;
         if (valid_in && ready_in) begin
            q.push_back(model(bt[sent]));
            sent++;
         end
         @(posedge clk); #1;
      end
      chk("bp_all_out", 64'(got), 64'd5);
      valid_in = 1'b0; ready_out = 1'b1;
      @(posedge clk); #1;

      // reset with the pipeline full discards everything in flight
      drive(rand_txn(1'b0)); valid_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_pre_valid", 64'(valid_out), 64'd1);
      valid_in = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_mid_valid_out", 64'(valid_out), 64'd0);
      chk("rst_mid_ready_in", 64'(ready_in), 64'd1);
      chk("rst_mid_acc", 64'(acc_sig), 64'd0);
      repeat (4) begin
         @(posedge clk); #1;
         chk("rst_mid_discard", 64'(valid_out), 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
